// File: rtl/frag_out_tx_if.sv
// Fragment transmitter bus: upstream hit/triangle-end inputs and downstream fragment stream.
// The master side feeds hits and consumes fragments. The slave side is the transmitter.
interface frag_out_tx_if #(
   parameter int SIGFIG = 24,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int CNT_W  = 16
);
   logic                     hit_valid_i;
   logic [SIGFIG*AXIS-1:0]   hit_i;
   logic [SIGFIG*COLORS-1:0] color_i;
   logic                     tri_end_i;
   logic                     stall_o;
   logic                     frag_valid_o;
   logic                     frag_ready_i;
   logic [SIGFIG*AXIS-1:0]   frag_hit_o;
   logic [SIGFIG*COLORS-1:0] frag_color_o;
   logic                     frag_last_o;
   logic                     tri_done_o;
   logic [CNT_W-1:0]         tri_hits_o;
   logic                     ovf_err_o;

   modport master (
      output hit_valid_i, hit_i, color_i, tri_end_i, frag_ready_i,
      input  stall_o, frag_valid_o, frag_hit_o, frag_color_o, frag_last_o,
             tri_done_o, tri_hits_o, ovf_err_o
   );

   modport slave (
      input  hit_valid_i, hit_i, color_i, tri_end_i, frag_ready_i,
      output stall_o, frag_valid_o, frag_hit_o, frag_color_o, frag_last_o,
             tri_done_o, tri_hits_o, ovf_err_o
   );
endinterface

// File: rtl/frag_out_tx.sv
// Fragment transmitter: holds the newest hit in a pending slot until the next hit or triangle end
// decides its last flag. It then queues the hit in a register FIFO and reports per-triangle hit counts.
module frag_out_tx #(
   parameter int SIGFIG = 24,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   frag_out_tx_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int HW = SIGFIG * AXIS;
   localparam int CW = SIGFIG * COLORS;

   logic [HW-1:0] mem_hit   [DEPTH];
   logic [CW-1:0] mem_color [DEPTH];
   logic          mem_last  [DEPTH];

   logic          pend_valid;
   logic [HW-1:0] pend_hit;
   logic [CW-1:0] pend_color;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic [CNT_W-1:0] hit_cnt;

   logic             tri_done_q;
   logic [CNT_W-1:0] tri_hits_q;
   logic             stall_q;
   logic             ovf_q;

   logic hit_acc;
   logic push;
   logic pop;
   logic fifo_empty;
   logic fifo_full;
   logic push_ok;
   logic drop;

   // A triangle end wins over a coincident hit. The pending entry leaves on either event.
   always_comb begin
      hit_acc    = bus.hit_valid_i & ~bus.tri_end_i;
      push       = pend_valid & (hit_acc | bus.tri_end_i);
      fifo_empty = (count == '0);
      fifo_full  = (count == (PW+1)'(DEPTH));
      pop        = ~fifo_empty & bus.frag_ready_i;
      push_ok    = push & (~fifo_full | pop);
      drop       = push & fifo_full & ~pop;
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_hit[wr_ptr]   <= pend_hit;
         mem_color[wr_ptr] <= pend_color;
         mem_last[wr_ptr]  <= bus.tri_end_i;
      end
      if (hit_acc) begin
         pend_hit   <= bus.hit_i;
         pend_color <= bus.color_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_valid <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hit_cnt    <= '0;
         tri_done_q <= 1'b0;
         tri_hits_q <= '0;
         stall_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (bus.tri_end_i)
            pend_valid <= 1'b0;
         else if (hit_acc)
            pend_valid <= 1'b1;

         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);

         case ({push_ok, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase

         // Threshold leaves room for the two hits already in flight when upstream reacts.
         stall_q <= (count >= (PW+1)'(DEPTH - 2));

         if (drop)
            ovf_q <= 1'b1;

         tri_done_q <= bus.tri_end_i;
         if (bus.tri_end_i) begin
            tri_hits_q <= hit_cnt;
            hit_cnt    <= '0;
         end else if (hit_acc && hit_cnt != '1) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.frag_valid_o = ~fifo_empty;
   assign bus.frag_hit_o   = mem_hit[rd_ptr];
   assign bus.frag_color_o = mem_color[rd_ptr];
   assign bus.frag_last_o  = ~fifo_empty & mem_last[rd_ptr];
   assign bus.tri_done_o   = tri_done_q;
   assign bus.tri_hits_o   = tri_hits_q;
   assign bus.stall_o      = stall_q;
   assign bus.ovf_err_o    = ovf_q;
endmodule

// File: tb/tb_frag_out_tx.sv
// Directed bench for frag_out_tx: each scenario task drives hits/ends and checks fragments,
// last flags, per-triangle counts, stall and overflow against hand-derived expectations.
module tb_frag_out_tx;
   localparam int SIGFIG = 24;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [71:0] hit;
      logic [71:0] color;
      logic        last;
   } frag_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   passed = 0;
   int   total  = 0;

   frag_t       frag_q[$];
   logic [15:0] done_q[$];

   always #5 clk = ~clk;

   frag_out_tx_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .CNT_W(CNT_W)) bus ();

   frag_out_tx #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [71:0] mk_hit(int id);
      return {24'(id), 24'(id + 1000), 24'(-id)};
   endfunction

   function automatic logic [71:0] mk_color(int id);
      return {24'(id * 7), 24'(id + 55), 24'(id ^ 32'h000ABCDE)};
   endfunction

   // Everything handed downstream and every triangle report is logged mid-cycle for later comparison.
   always @(negedge clk) begin
      if (rst && bus.frag_valid_o && bus.frag_ready_i)
         frag_q.push_back('{hit: bus.frag_hit_o, color: bus.frag_color_o, last: bus.frag_last_o});
      if (rst && bus.tri_done_o)
         done_q.push_back(bus.tri_hits_o);
      if (rst)
         assert (!(bus.hit_valid_i && bus.tri_end_i)) else $error("[TB] hit_valid_i and tri_end_i together");
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      bus.hit_valid_i = 1'b0;
      bus.tri_end_i   = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_hit(int id);
      bus.hit_valid_i = 1'b1;
      bus.tri_end_i   = 1'b0;
      bus.hit_i       = mk_hit(id);
      bus.color_i     = mk_color(id);
      step();
      bus.hit_valid_i = 1'b0;
   endtask

   task automatic send_end();
      bus.hit_valid_i = 1'b0;
      bus.tri_end_i   = 1'b1;
      step();
      bus.tri_end_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.hit_valid_i  = 1'b0;
      bus.tri_end_i    = 1'b0;
      bus.frag_ready_i = 1'b0;
      bus.hit_i        = '0;
      bus.color_i      = '0;
      rst = 1'b0;
      step();
      step();
      total++; if (bus.frag_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.frag_valid_o); else passed++;
      total++; if (bus.frag_last_o !== 1'b0) $display("[TB] FAIL reset_last: got %b expected 0", bus.frag_last_o); else passed++;
      total++; if (bus.tri_done_o !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.tri_done_o); else passed++;
      total++; if (bus.tri_hits_o !== 16'd0) $display("[TB] FAIL reset_hits: got %0d expected 0", bus.tri_hits_o); else passed++;
      total++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall_o); else passed++;
      total++; if (bus.ovf_err_o !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf_err_o); else passed++;
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int ids[3]   = '{11, 12, 13};
      logic lst[3] = '{1'b0, 1'b0, 1'b1};
      frag_q.delete();
      done_q.delete();
      bus.frag_ready_i = 1'b1;
      send_hit(ids[0]);
      total++; if (bus.frag_valid_o !== 1'b0) $display("[TB] FAIL basic_lat_a: got %b expected 0", bus.frag_valid_o); else passed++;
      send_hit(ids[1]);
      total++; if (bus.frag_valid_o !== 1'b1) $display("[TB] FAIL basic_lat_b: got %b expected 1", bus.frag_valid_o); else passed++;
      send_hit(ids[2]);
      send_end();
      total++; if (bus.tri_done_o !== 1'b1) $display("[TB] FAIL basic_done: got %b expected 1", bus.tri_done_o); else passed++;
      total++; if (bus.tri_hits_o !== 16'd3) $display("[TB] FAIL basic_hits: got %0d expected 3", bus.tri_hits_o); else passed++;
      idle(1);
      total++; if (bus.tri_done_o !== 1'b0) $display("[TB] FAIL basic_pulse: got %b expected 0", bus.tri_done_o); else passed++;
      idle(3);
      total++; if (frag_q.size() != 3) $display("[TB] FAIL basic_count: got %0d expected 3", frag_q.size()); else passed++;
      for (int i = 0; i < 3 && i < frag_q.size(); i++) begin
         total++;
         if (frag_q[i].hit !== mk_hit(ids[i]) || frag_q[i].color !== mk_color(ids[i]) || frag_q[i].last !== lst[i])
            $display("[TB] FAIL basic_frag%0d: got hit %h color %h last %b expected hit %h color %h last %b",
                     i, frag_q[i].hit, frag_q[i].color, frag_q[i].last, mk_hit(ids[i]), mk_color(ids[i]), lst[i]);
         else passed++;
      end
   endtask

   task automatic test_empty_tri();
      frag_q.delete();
      send_end();
      total++; if (bus.tri_done_o !== 1'b1) $display("[TB] FAIL empty_done: got %b expected 1", bus.tri_done_o); else passed++;
      total++; if (bus.tri_hits_o !== 16'd0) $display("[TB] FAIL empty_hits: got %0d expected 0", bus.tri_hits_o); else passed++;
      idle(3);
      total++; if (frag_q.size() != 0) $display("[TB] FAIL empty_frags: got %0d expected 0", frag_q.size()); else passed++;
   endtask

   task automatic test_stall();
      frag_q.delete();
      bus.frag_ready_i = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         total++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL stall_low%0d: got %b expected 0", k, bus.stall_o); else passed++;
         send_hit(20 + k);
      end
      idle(1);
      total++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL stall_high: got %b expected 1", bus.stall_o); else passed++;
      bus.frag_ready_i = 1'b1;
      send_end();
      total++; if (bus.tri_hits_o !== 16'd7) $display("[TB] FAIL stall_hits: got %0d expected 7", bus.tri_hits_o); else passed++;
      idle(10);
      total++; if (bus.ovf_err_o !== 1'b0) $display("[TB] FAIL stall_ovf: got %b expected 0", bus.ovf_err_o); else passed++;
      total++; if (frag_q.size() != 7) $display("[TB] FAIL stall_count: got %0d expected 7", frag_q.size()); else passed++;
      for (int i = 0; i < 7 && i < frag_q.size(); i++) begin
         total++;
         if (frag_q[i].hit !== mk_hit(21 + i) || frag_q[i].last !== (i == 6))
            $display("[TB] FAIL stall_frag%0d: got hit %h last %b expected hit %h last %b",
                     i, frag_q[i].hit, frag_q[i].last, mk_hit(21 + i), (i == 6));
         else passed++;
      end
   endtask

   task automatic test_overflow();
      int exp_ids[9] = '{41, 42, 43, 44, 45, 46, 47, 48, 50};
      frag_q.delete();
      bus.frag_ready_i = 1'b0;
      for (int k = 1; k <= 9; k++) send_hit(40 + k);
      total++; if (bus.ovf_err_o !== 1'b0) $display("[TB] FAIL ovf_before: got %b expected 0", bus.ovf_err_o); else passed++;
      send_hit(50);
      total++; if (bus.ovf_err_o !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", bus.ovf_err_o); else passed++;
      bus.frag_ready_i = 1'b1;
      idle(10);
      total++; if (bus.ovf_err_o !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.ovf_err_o); else passed++;
      total++; if (frag_q.size() != 8) $display("[TB] FAIL ovf_drained: got %0d expected 8", frag_q.size()); else passed++;
      send_end();
      total++; if (bus.tri_hits_o !== 16'd10) $display("[TB] FAIL ovf_hits: got %0d expected 10", bus.tri_hits_o); else passed++;
      idle(3);
      total++; if (frag_q.size() != 9) $display("[TB] FAIL ovf_count: got %0d expected 9", frag_q.size()); else passed++;
      for (int i = 0; i < 9 && i < frag_q.size(); i++) begin
         total++;
         if (frag_q[i].hit !== mk_hit(exp_ids[i]) || frag_q[i].last !== (i == 8))
            $display("[TB] FAIL ovf_frag%0d: got hit %h last %b expected hit %h last %b",
                     i, frag_q[i].hit, frag_q[i].last, mk_hit(exp_ids[i]), (i == 8));
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int ids[3]   = '{61, 62, 63};
      logic lst[3] = '{1'b0, 1'b1, 1'b1};
      frag_q.delete();
      done_q.delete();
      bus.frag_ready_i = 1'b1;
      send_hit(ids[0]);
      send_hit(ids[1]);
      send_end();
      send_hit(ids[2]);
      send_end();
      idle(4);
      total++; if (done_q.size() != 2) $display("[TB] FAIL b2b_dones: got %0d expected 2", done_q.size()); else passed++;
      if (done_q.size() == 2) begin
         total++; if (done_q[0] !== 16'd2) $display("[TB] FAIL b2b_hits0: got %0d expected 2", done_q[0]); else passed++;
         total++; if (done_q[1] !== 16'd1) $display("[TB] FAIL b2b_hits1: got %0d expected 1", done_q[1]); else passed++;
      end
      total++; if (frag_q.size() != 3) $display("[TB] FAIL b2b_count: got %0d expected 3", frag_q.size()); else passed++;
      for (int i = 0; i < 3 && i < frag_q.size(); i++) begin
         total++;
         if (frag_q[i].hit !== mk_hit(ids[i]) || frag_q[i].last !== lst[i])
            $display("[TB] FAIL b2b_frag%0d: got hit %h last %b expected hit %h last %b",
                     i, frag_q[i].hit, frag_q[i].last, mk_hit(ids[i]), lst[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      frag_q.delete();
      bus.frag_ready_i = 1'b0;
      send_hit(71);
      send_hit(72);
      send_hit(73);
      rst = 1'b0;
      step();
      rst = 1'b1;
      total++; if (bus.frag_valid_o !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", bus.frag_valid_o); else passed++;
      total++; if (bus.ovf_err_o !== 1'b0) $display("[TB] FAIL midrst_ovf: got %b expected 0", bus.ovf_err_o); else passed++;
      bus.frag_ready_i = 1'b1;
      send_end();
      total++; if (bus.tri_done_o !== 1'b1) $display("[TB] FAIL midrst_done: got %b expected 1", bus.tri_done_o); else passed++;
      total++; if (bus.tri_hits_o !== 16'd0) $display("[TB] FAIL midrst_hits: got %0d expected 0", bus.tri_hits_o); else passed++;
      idle(4);
      total++; if (frag_q.size() != 0) $display("[TB] FAIL midrst_frags: got %0d expected 0", frag_q.size()); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_tri();
      test_stall();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/frag_out_tx.md
Name: frag_out_tx

Overview:
Fragment transmitter at the output of the sample-test stage. It accepts per-cycle hit fragments and per-triangle end markers from the rasterizer pipe. It buffers the fragments, tags the last fragment of each triangle, and sends them downstream over a valid/ready interface. It also reports the per-triangle hit count at each triangle boundary, which is the producer-side counterpart of the hit-count scoreboard.

Parameters:
- SIGFIG, 24, bits in each position/color field
- AXIS, 3, position fields per fragment (x,y,z)
- COLORS, 3, color channels per fragment
- DEPTH, 8, FIFO entries; power of 2, minimum 4
- CNT_W, 16, width of the hit counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- hit_valid_i  in  1  fragment valid this cycle
- hit_i  in  SIGFIG x AXIS  fragment position, signed
- color_i  in  SIGFIG x COLORS  fragment color, unsigned
- tri_end_i  in  1  current triangle finished; must not coincide with hit_valid_i
- stall_o  out  1  backpressure to upstream; upstream stops new hits the cycle after it is seen high
- frag_valid_o  out  1  head fragment available
- frag_ready_i  in  1  downstream accepts head fragment
- frag_hit_o  out  SIGFIG x AXIS  head position
- frag_color_o  out  SIGFIG x COLORS  head color
- frag_last_o  out  1  head fragment is the last of its triangle
- tri_done_o  out  1  one-cycle pulse: triangle closed
- tri_hits_o  out  CNT_W  hit count of the closed triangle; valid while tri_done_o=1
- ovf_err_o  out  1  sticky: a fragment was dropped on FIFO overflow

Behaviour:
- Reset (rst=0 at a posedge) values:
  - frag_valid_o=0, frag_last_o=0, tri_done_o=0, tri_hits_o=0, stall_o=0, ovf_err_o=0
  - FIFO empty, pending register empty, hit counter 0
  - frag_hit_o and frag_color_o are don't-care while frag_valid_o=0
- Reset mid-triangle: all buffered and pending fragments are discarded; no tri_done_o is emitted for the open triangle.
- Pending register (one entry plus a valid bit) holds the most recent hit, so the last flag can be applied when tri_end_i arrives later.
- Hit accepted (hit_valid_i=1):
  - If pending is valid, its contents are pushed to the FIFO with last=0.
  - The new hit loads into pending.
  - The hit counter increments, saturating at 2^CNT_W-1.
- tri_end_i=1:
  - If pending is valid, it is pushed with last=1 and pending is cleared.
  - On the next cycle, tri_done_o=1 and tri_hits_o equals the counter value including all hits up to tri_end_i.
  - The counter resets to 0, so a hit in the cycle after tri_end_i counts as 1 for the next triangle.
- tri_end_i with zero hits: tri_done_o pulses with tri_hits_o=0; no fragment is emitted.
- hit_valid_i and tri_end_i high together is a protocol error: the bench asserts on it, and the RTL gives tri_end_i priority and drops the hit.
- FIFO:
  - At most one push and one pop per cycle; data is held in registers.
  - frag_valid_o = not empty; head data and head last flag are driven directly from the read pointer.
  - Pop occurs when frag_valid_o & frag_ready_i.
  - Push and pop in the same cycle are both performed, including when the FIFO is full; count is unchanged.
  - Push when full with no pop: the entry is dropped and ovf_err_o is set and held until reset.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- stall_o is registered: it is 1 in the cycle after count >= DEPTH-2, else 0.
- Latency (frag_ready_i=1): a hit at cycle N is visible on frag_valid_o at cycle M+1, where M is the cycle of the next hit or tri_end_i.
- Ordering: fragments leave in arrival order; triangles never interleave.
- frag_valid_o is never deasserted and head data never changes while frag_valid_o=1 and frag_ready_i=0.

Test Plan:
- Hits A,B,C on cycles 1-3, tri_end_i on cycle 4, frag_ready_i=1 -> frags A,B,C emitted with frag_last_o=0,0,1; tri_done_o at cycle 5 with tri_hits_o=3.
- tri_end_i alone after reset -> tri_done_o pulse with tri_hits_o=0; frag_valid_o stays 0.
- frag_ready_i=0, 7 consecutive hits honoring stall_o -> stall_o rises after 6 FIFO entries; then frag_ready_i=1 and tri_end_i -> all 7 frags emitted in order, last on the 7th, ovf_err_o=0.
- DEPTH=8, frag_ready_i=0, 10 hits ignoring stall_o -> 9th push (hit 9) dropped, ovf_err_o=1 sticky; after release the FIFO drains hits 1-8, then tri_end_i emits hit 10 with last=1; tri_hits_o=10.
- Back-to-back triangles: hits P,Q; tri_end_i; hit R the next cycle; tri_end_i -> tri_hits_o=2 then 1; frag_last_o set on Q and R only.
- 3 hits, rst=0 for one cycle, then tri_end_i -> frag_valid_o=0 after reset; tri_hits_o=0; no stale fragments emitted.
